// File: rtl/prio_stream_mux_pkg.sv
// Shared types for the fixed-priority stream mux: lock FSM states and index-width helper.
package prio_stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // A source index needs at least one bit, even for a 2:1 mux.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_stream_mux_out_reg.sv
// One-entry valid/ready register for payload plus source index; accepts a new beat while draining.
module prio_stream_mux_out_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [IDX_WIDTH-1:0]  in_idx_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [IDX_WIDTH-1:0]  out_idx_o
);

  logic full_q;

  assign in_ready_o  = ~full_q | out_ready_i;
  assign out_valid_o = full_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q     <= 1'b0;
      out_data_o <= '0;
      out_idx_o  <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      full_q     <= 1'b1;
      out_data_o <= in_data_i;
      out_idx_o  <= in_idx_i;
    end else if (out_ready_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/prio_stream_mux.sv
// Fixed-priority N:1 valid/ready stream mux with grant lock-in under backpressure.
// Define PRIO_STREAM_MUX_OUT_REG_EN to insert a one-entry output register (lock FSM then idles).
module prio_stream_mux
  import prio_stream_mux_pkg::*;
#(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_WIDTH  = idx_width(NUM_IN)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NUM_IN-1:0]                inp_valid_i,
  output logic [NUM_IN-1:0]                inp_ready_o,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0] inp_data_i,
  output logic                             oup_valid_o,
  input  logic                             oup_ready_i,
  output logic [DATA_WIDTH-1:0]            oup_data_o,
  output logic [IDX_WIDTH-1:0]             oup_idx_o,
  output logic                             lock_o
);

  lock_state_e           state_q;
  logic [IDX_WIDTH-1:0]  lock_idx_q;
  logic [NUM_IN-1:0]     prio_oh;
  logic [NUM_IN-1:0]     grant_oh;
  logic [IDX_WIDTH-1:0]  prio_idx;
  logic [IDX_WIDTH-1:0]  grant_idx;
  logic                  grant_valid;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  path_ready;

  // Lowest set valid bit wins; while locked the stored index overrides priority.
  always_comb begin
    prio_oh  = inp_valid_i & (~inp_valid_i + NUM_IN'(1));
    prio_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (prio_oh[i]) prio_idx = prio_idx | IDX_WIDTH'(i);
    end
    if (state_q == LOCKED) begin
      grant_idx = lock_idx_q;
      grant_oh  = NUM_IN'(1) << lock_idx_q;
    end else begin
      grant_idx = prio_idx;
      grant_oh  = prio_oh;
    end
    grant_valid = |(grant_oh & inp_valid_i);
    grant_data  = inp_data_i[grant_idx];
  end

  assign inp_ready_o = grant_oh & {NUM_IN{path_ready & ~flush_i & rst_ni}};

`ifdef PRIO_STREAM_MUX_OUT_REG_EN
  logic reg_valid;
  logic reg_in_ready;

  assign state_q    = IDLE;
  assign lock_idx_q = '0;
  assign path_ready = reg_in_ready;
  assign lock_o     = 1'b0;
  // Flush hides the held beat so the consumer never sees a handshake that gets discarded.
  assign oup_valid_o = reg_valid & ~flush_i;

  prio_stream_mux_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .in_valid_i (grant_valid & ~flush_i),
    .in_ready_o (reg_in_ready),
    .in_data_i  (grant_data),
    .in_idx_i   (grant_idx),
    .out_valid_o(reg_valid),
    .out_ready_i(oup_ready_i),
    .out_data_o (oup_data_o),
    .out_idx_o  (oup_idx_o)
  );
`else
  assign path_ready  = oup_ready_i;
  assign oup_valid_o = grant_valid & ~flush_i & rst_ni;
  assign oup_data_o  = grant_data;
  assign oup_idx_o   = grant_idx;
  assign lock_o      = (state_q == LOCKED);

  // An offered but unaccepted beat freezes the grant; a retracted valid also releases it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid && !oup_ready_i) begin
            state_q    <= LOCKED;
            lock_idx_q <= grant_idx;
          end
        end
        LOCKED: begin
          if (!grant_valid || oup_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

endmodule
